// File: rtl/hc_sr04_ranger_if.sv
// Sensor-side and result-side signals of one HC-SR04 ranging channel.
interface hc_sr04_ranger_if;
   logic        en;
   logic        echo;
   logic        trig;
   logic [15:0] echo_us;
   logic [15:0] distance_cm;
   logic        dist_valid;
   logic        err_timeout;
   logic        busy;

   // Controller / sensor side: drives enable and echo, consumes results.
   modport master (
      output en, echo,
      input  trig, echo_us, distance_cm, dist_valid, err_timeout, busy
   );

   // Ranger side.
   modport slave (
      input  en, echo,
      output trig, echo_us, distance_cm, dist_valid, err_timeout, busy
   );
endinterface

// File: rtl/hc_sr04_ranger.sv
// HC-SR04 ranger: periodic trigger, echo width timing in 1 us ticks,
// width-to-centimetre conversion by repeated subtraction.
module hc_sr04_ranger #(
   parameter int unsigned TRIG_US         = 10,
   parameter int unsigned WAIT_TIMEOUT_US = 2000,
   parameter int unsigned ECHO_TIMEOUT_US = 30000,
   parameter int unsigned PERIOD_US       = 60000,
   parameter int unsigned CM_DIV          = 58
) (
   input  logic             clk_50M,
   input  logic             rst_n,
   input  logic             clk_1M,
   hc_sr04_ranger_if.slave  bus
);

   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] TRIG_LAST  = CW'(TRIG_US - 1);
   localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_TIMEOUT_US - 1);
   localparam logic [CW-1:0] ECHO_LAST  = CW'(ECHO_TIMEOUT_US - 1);
   localparam logic [CW-1:0] PERIOD_LIM = CW'(PERIOD_US);
   localparam logic [CW-1:0] DIV        = CW'(CM_DIV);
   localparam logic [CW-1:0] ONE        = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_WAIT_ECHO, S_MEASURE, S_CALC, S_DONE, S_HOLD
   } state_e;

   state_e          state_q, state_d;
   logic            clk_1M_d_q;
   logic            echo_m_q, echo_s_q, echo_d_q;
   logic [CW-1:0]   period_cnt_q, period_cnt_d;
   logic [CW-1:0]   trig_cnt_q, trig_cnt_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CW-1:0]   us_cnt_q, us_cnt_d;
   logic [CW-1:0]   rem_q, rem_d;
   logic [CW-1:0]   quo_q, quo_d;
   logic            timeout_q, timeout_d;
   logic            trig_q, trig_d;
   logic [CW-1:0]   echo_us_q, echo_us_d;
   logic [CW-1:0]   distance_cm_q, distance_cm_d;
   logic            dist_valid_q, dist_valid_d;
   logic            err_timeout_q, err_timeout_d;
   logic            busy_q, busy_d;

   logic tick_c, rise_c, fall_c;

   assign tick_c = clk_1M & ~clk_1M_d_q;
   assign rise_c = echo_s_q & ~echo_d_q;
   assign fall_c = ~echo_s_q & echo_d_q;

   // Tick edge detector and echo synchronizer / edge register.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         clk_1M_d_q <= 1'b0;
         echo_m_q   <= 1'b0;
         echo_s_q   <= 1'b0;
         echo_d_q   <= 1'b0;
      end else begin
         clk_1M_d_q <= clk_1M;
         echo_m_q   <= bus.echo;
         echo_s_q   <= echo_m_q;
         echo_d_q   <= echo_s_q;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         period_cnt_q  <= '0;
         trig_cnt_q    <= '0;
         wait_cnt_q    <= '0;
         us_cnt_q      <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         timeout_q     <= 1'b0;
         trig_q        <= 1'b0;
         echo_us_q     <= '0;
         distance_cm_q <= '0;
         dist_valid_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         period_cnt_q  <= period_cnt_d;
         trig_cnt_q    <= trig_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         us_cnt_q      <= us_cnt_d;
         rem_q         <= rem_d;
         quo_q         <= quo_d;
         timeout_q     <= timeout_d;
         trig_q        <= trig_d;
         echo_us_q     <= echo_us_d;
         distance_cm_q <= distance_cm_d;
         dist_valid_q  <= dist_valid_d;
         err_timeout_q <= err_timeout_d;
         busy_q        <= busy_d;
      end
   end

   // Next-state, counter and output logic; outputs are computed from the
   // next state so they line up with the state register.
   always_comb begin
      state_d       = state_q;
      period_cnt_d  = period_cnt_q;
      trig_cnt_d    = trig_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      us_cnt_d      = us_cnt_q;
      rem_d         = rem_q;
      quo_d         = quo_q;
      timeout_d     = timeout_q;
      echo_us_d     = echo_us_q;
      distance_cm_d = distance_cm_q;
      err_timeout_d = err_timeout_q;
      dist_valid_d  = 1'b0;
      trig_d        = 1'b0;
      busy_d        = 1'b0;

      if (state_q != S_IDLE && tick_c && period_cnt_q < PERIOD_LIM) begin
         period_cnt_d = period_cnt_q + ONE;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.en && tick_c) begin
               state_d      = S_TRIG;
               period_cnt_d = '0;
               trig_cnt_d   = '0;
               timeout_d    = 1'b0;
            end
         end
         S_TRIG: begin
            if (tick_c) begin
               if (trig_cnt_q == TRIG_LAST) begin
                  state_d    = S_WAIT_ECHO;
                  wait_cnt_d = '0;
               end else begin
                  trig_cnt_d = trig_cnt_q + ONE;
               end
            end
         end
         S_WAIT_ECHO: begin
            if (rise_c) begin
               state_d  = S_MEASURE;
               us_cnt_d = '0;
            end else if (tick_c) begin
               wait_cnt_d = wait_cnt_q + ONE;
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d   = S_DONE;
                  timeout_d = 1'b1;
                  us_cnt_d  = '0;
               end
            end
         end
         S_MEASURE: begin
            // A fall in the same cycle as a tick ends the pulse uncounted.
            if (fall_c) begin
               state_d = S_CALC;
               rem_d   = us_cnt_q;
               quo_d   = '0;
            end else if (tick_c) begin
               us_cnt_d = us_cnt_q + ONE;
               if (us_cnt_q == ECHO_LAST) begin
                  state_d   = S_DONE;
                  timeout_d = 1'b1;
               end
            end
         end
         S_CALC: begin
            if (rem_q >= DIV) begin
               rem_d = rem_q - DIV;
               quo_d = quo_q + ONE;
            end else begin
               state_d   = S_DONE;
               timeout_d = 1'b0;
            end
         end
         S_DONE: begin
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (period_cnt_q >= PERIOD_LIM) begin
               if (bus.en) begin
                  state_d      = S_TRIG;
                  period_cnt_d = '0;
                  trig_cnt_d   = '0;
                  timeout_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_DONE) begin
         echo_us_d     = us_cnt_d;
         distance_cm_d = timeout_d ? 16'hFFFF : quo_d;
         err_timeout_d = timeout_d;
         dist_valid_d  = 1'b1;
      end
      trig_d = (state_d == S_TRIG);
      busy_d = (state_d != S_IDLE);
   end

   assign bus.trig        = trig_q;
   assign bus.echo_us     = echo_us_q;
   assign bus.distance_cm = distance_cm_q;
   assign bus.dist_valid  = dist_valid_q;
   assign bus.err_timeout = err_timeout_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_hc_sr04_ranger.sv
// Scoreboard bench for hc_sr04_ranger. The 1 us tick source runs at one
// tick per two clk_50M cycles so that full periods stay short in cycles.
module tb_hc_sr04_ranger;

   localparam int unsigned TRIG_US   = 10;
   localparam int unsigned WAIT_TO   = 500;
   localparam int unsigned ECHO_TO   = 2000;
   localparam int unsigned PERIOD_US = 3000;
   localparam int unsigned CM_DIV    = 58;
   localparam int CPT = 2;   // clk_50M cycles per tick

   logic clk_50M = 1'b0;
   logic clk_1M  = 1'b0;
   logic rst_n   = 1'b0;

   hc_sr04_ranger_if bus();

   hc_sr04_ranger #(
      .TRIG_US         (TRIG_US),
      .WAIT_TIMEOUT_US (WAIT_TO),
      .ECHO_TIMEOUT_US (ECHO_TO),
      .PERIOD_US       (PERIOD_US),
      .CM_DIV          (CM_DIV)
   ) dut (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .clk_1M  (clk_1M),
      .bus     (bus)
   );

   always #5 clk_50M = ~clk_50M;
   always @(negedge clk_50M) clk_1M <= ~clk_1M;

   int cyc = 0;
   always @(posedge clk_50M) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] us;
      logic [15:0] cm;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                  tag, obs, obs, exp, exp, cyc);
      end
   endtask

   // Returns want when got is within slack of it, otherwise got itself.
   function automatic int tol(input int got, input int want, input int slack);
      return (got >= want - slack && got <= want + slack) ? want : got;
   endfunction

   // Result monitor: every dist_valid cycle must match the oldest expectation.
   always @(negedge clk_50M) begin
      if (rst_n === 1'b1 && bus.dist_valid === 1'b1) begin
         check_eq("valid_expected", 32'(sb_q.size() > 0), 32'(1));
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_eq("echo_us",     32'(bus.echo_us),     32'(mon_e.us));
            check_eq("distance_cm", 32'(bus.distance_cm), 32'(mon_e.cm));
            check_eq("err_timeout", 32'(bus.err_timeout), 32'(mon_e.err));
         end
      end
   end

   task automatic push_exp(input logic [15:0] us, input logic [15:0] cm, input logic err);
      exp_t e;
      e.us = us; e.cm = cm; e.err = err;
      sb_q.push_back(e);
   endtask

   task automatic wait_trig(input string tag, input logic lvl, input int budget, output int at);
      int  n;
      bit  seen;
      n = 0; seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clk_50M);
         n++;
         if (bus.trig === lvl) seen = 1'b1;
      end
      at = cyc;
      check_eq(tag, 32'(seen), 32'(1));
   endtask

   task automatic wait_sb_empty(input string tag, input int budget);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clk_50M);
         n++;
      end
      check_eq(tag, 32'(sb_q.size()), 32'(0));
   endtask

   // Leaves the bench just after a negedge where clk_1M will be 0 at the
   // next posedge, so the synchronised edge lands between ticks.
   task automatic align_tick();
      do begin
         @(negedge clk_50M);
         #1;
      end while (clk_1M !== 1'b0);
   endtask

   task automatic drive_echo(input int width_us);
      align_tick();
      bus.echo = 1'b1;
      repeat (CPT * width_us) @(negedge clk_50M);
      #1 bus.echo = 1'b0;
   endtask

   task automatic do_reset();
      bus.en = 1'b0;
      @(negedge clk_50M);
      rst_n = 1'b0;
      repeat (3) @(negedge clk_50M);
      rst_n = 1'b1;
   endtask

   task automatic check_zero(input string pfx);
      check_eq({pfx, "_trig"},   32'(bus.trig),        32'(0));
      check_eq({pfx, "_us"},     32'(bus.echo_us),     32'(0));
      check_eq({pfx, "_cm"},     32'(bus.distance_cm), 32'(0));
      check_eq({pfx, "_valid"},  32'(bus.dist_valid),  32'(0));
      check_eq({pfx, "_err"},    32'(bus.err_timeout), 32'(0));
      check_eq({pfx, "_busy"},   32'(bus.busy),        32'(0));
   endtask

   // One measurement from IDLE with an echo gap_us after trig falls.
   task automatic run_meas(input string tag, input int width_us, input int gap_us,
                           input logic [15:0] exp_cm);
      int r, f;
      bus.en = 1'b1;
      push_exp(16'(width_us), exp_cm, 1'b0);
      wait_trig({tag, "_rise"}, 1'b1, 10, r);
      wait_trig({tag, "_fall"}, 1'b0, 100, f);
      repeat (CPT * gap_us) @(negedge clk_50M);
      drive_echo(width_us);
      wait_sb_empty({tag, "_result"}, 400);
      do_reset();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r_prev, r, f, n;
      bit seen;
      int widths[3];
      logic [15:0] cms[3];
      widths = '{57, 58, 115};
      cms    = '{16'd0, 16'd1, 16'd1};

      bus.en   = 1'b0;
      bus.echo = 1'b0;

      // T1: reset and idle
      rst_n = 1'b0;
      repeat (5) @(negedge clk_50M);
      check_zero("t1_reset");
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (CPT * 100) begin
         @(negedge clk_50M);
         if (bus.trig === 1'b1) seen = 1'b1;
      end
      check_eq("t1_no_trig", 32'(seen), 32'(0));
      check_zero("t1_idle");

      // T2: trigger shape, period, timeout results with no echo
      bus.en = 1'b1;
      r_prev = 0;
      for (int k = 0; k < 3; k++) begin
         push_exp(16'd0, 16'hFFFF, 1'b1);
         wait_trig("t2_rise", 1'b1, (k == 0) ? 10 : 7000, r);
         if (k > 0) check_eq("t2_period", 32'(tol(r - r_prev, CPT * 3000, 2)), 32'(CPT * 3000));
         wait_trig("t2_fall", 1'b0, 100, f);
         check_eq("t2_width", 32'(tol(f - r, CPT * 10, CPT)), 32'(CPT * 10));
         r_prev = r;
      end
      wait_sb_empty("t2_drain", 2000);
      do_reset();

      // T3: nominal measurement
      run_meas("t3", 1160, 200, 16'd20);

      // T4: divide boundary
      for (int i = 0; i < 3; i++) run_meas("t4", widths[i], 50, cms[i]);

      // T5: overlong echo saturates, schedule unchanged
      bus.en = 1'b1;
      push_exp(16'd2000, 16'hFFFF, 1'b1);
      wait_trig("t5_rise", 1'b1, 10, r_prev);
      wait_trig("t5_fall", 1'b0, 100, f);
      repeat (CPT * 50) @(negedge clk_50M);
      drive_echo(2500);
      check_eq("t5_result", 32'(sb_q.size()), 32'(0));
      wait_trig("t5_next_rise", 1'b1, 7000, r);
      check_eq("t5_period", 32'(tol(r - r_prev, CPT * 3000, 2)), 32'(CPT * 3000));
      do_reset();

      // T6a: en dropped during MEASURE
      bus.en = 1'b1;
      push_exp(16'd300, 16'd5, 1'b0);
      wait_trig("t6a_rise", 1'b1, 10, r);
      wait_trig("t6a_fall", 1'b0, 100, f);
      repeat (CPT * 50) @(negedge clk_50M);
      align_tick();
      bus.echo = 1'b1;
      repeat (CPT * 100) @(negedge clk_50M);
      bus.en = 1'b0;
      repeat (CPT * 200) @(negedge clk_50M);
      #1 bus.echo = 1'b0;
      wait_sb_empty("t6a_result", 400);
      n = 0;
      while (bus.busy !== 1'b0 && n < 7000) begin
         @(negedge clk_50M);
         n++;
      end
      check_eq("t6a_idle", 32'(bus.busy), 32'(0));
      seen = 1'b0;
      repeat (CPT * 500) begin
         @(negedge clk_50M);
         if (bus.trig === 1'b1) seen = 1'b1;
      end
      check_eq("t6a_no_trig", 32'(seen), 32'(0));
      check_eq("t6a_hold_us", 32'(bus.echo_us), 32'(300));

      // T6b: reset pulse during CALC
      bus.en = 1'b1;
      wait_trig("t6b_rise", 1'b1, 10, r);
      wait_trig("t6b_fall", 1'b0, 100, f);
      repeat (CPT * 50) @(negedge clk_50M);
      drive_echo(1160);
      repeat (4) @(negedge clk_50M);
      bus.en = 1'b0;
      rst_n  = 1'b0;
      repeat (2) @(negedge clk_50M);
      check_zero("t6b_in_reset");
      rst_n = 1'b1;
      repeat (100) @(negedge clk_50M);
      check_zero("t6b_after");

      check_eq("sb_final", 32'(sb_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
